// File: rtl/axis_demux_1_2.sv
// 1:2 AXI-Stream demultiplexer with a single registered output stage and per-port frame counters.
// Define AXIS_DEMUX_FRAME_LOCK_EN to lock each frame's destination to the sel value seen on its first beat.
module axis_demux_1_2 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  output logic [DATA_W-1:0] m0_tdata,
  output logic              m0_tvalid,
  input  logic              m0_tready,
  output logic              m0_tlast,
  output logic [DATA_W-1:0] m1_tdata,
  output logic              m1_tvalid,
  input  logic              m1_tready,
  output logic              m1_tlast,
  output logic [CNT_W-1:0]  frame_cnt0,
  output logic [CNT_W-1:0]  frame_cnt1
);

  logic              vld_p0;
  logic              last_p0;
  logic              dest_p0;
  logic [DATA_W-1:0] data_p0;

  logic dest_ready;
  logic accept;
  logic out_hs;
  logic route_dest;

  assign dest_ready = dest_p0 ? m1_tready : m0_tready;
  assign s_tready   = !vld_p0 || dest_ready;
  assign accept     = s_tvalid && s_tready;
  assign out_hs     = vld_p0 && dest_ready;

`ifdef AXIS_DEMUX_FRAME_LOCK_EN
  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   lock_dest, lock_dest_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lock_dest <= 1'b0;
    end else begin
      state     <= state_nxt;
      lock_dest <= lock_dest_nxt;
    end
  end

  // sel is only honoured on the first beat of a frame
  always_comb begin
    state_nxt     = state;
    lock_dest_nxt = lock_dest;
    route_dest    = sel;
    case (state)
      IDLE: begin
        route_dest = sel;
        if (accept) begin
          lock_dest_nxt = sel;
          if (!s_tlast) state_nxt = IN_FRAME;
        end
      end
      IN_FRAME: begin
        route_dest = lock_dest;
        if (accept && s_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  assign route_dest = sel;
`endif

  // stage p0: output register
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      dest_p0 <= 1'b0;
      data_p0 <= '0;
    end else if (accept) begin
      vld_p0  <= 1'b1;
      last_p0 <= s_tlast;
      dest_p0 <= route_dest;
      data_p0 <= s_tdata;
    end else if (out_hs) begin
      vld_p0  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt0 <= '0;
      frame_cnt1 <= '0;
    end else if (out_hs && last_p0) begin
      if (dest_p0) frame_cnt1 <= frame_cnt1 + CNT_W'(1);
      else         frame_cnt0 <= frame_cnt0 + CNT_W'(1);
    end
  end

  assign m0_tvalid = vld_p0 && !dest_p0;
  assign m1_tvalid = vld_p0 &&  dest_p0;
  assign m0_tlast  = last_p0 && m0_tvalid;
  assign m1_tlast  = last_p0 && m1_tvalid;
  assign m0_tdata  = data_p0;
  assign m1_tdata  = data_p0;

endmodule
